// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and index helper for the streaming channel mux.
// Revision    : 1.0
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_RR     = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    // Wide enough for any channel index of a 64-channel mux plus the count itself
    localparam int IDXW = 7;
    typedef logic [IDXW-1:0] idx_t;

    // Modulo-n increment with an explicit wrap, valid for non-power-of-2 n
    function automatic idx_t next_idx(input idx_t idx, input idx_t n);
        return (idx == n - idx_t'(1)) ? '0 : idx + idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_stream_n_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_stream_n_if
// Description : Input channel bundle and output stream of the channel mux.
// Revision    : 1.0
// ============================================================================
interface mux_stream_n_if #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    // master: producers plus consumer; slave: the mux itself
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_stream_n_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority arbiter, search starts at ptr.
// Revision    : 1.0
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    always_comb begin
        idx_t idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = idx_t'(ptr);
        for (int k = 0; k < N; k++) begin
            if (!gnt_vld && req[idx[SELW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[SELW-1:0];
            end
            idx = next_idx(idx, idx_t'(N));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_stream_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_stream_n
// Description : N-channel registered stream mux with direct, scan and RR modes.
// Revision    : 1.0
// ============================================================================
module mux_stream_n
    import mux_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)   // derived; leave at default
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_stream_n_if.slave      bus,
    input  mode_t              mode,
    input  logic [SELW-1:0]    sel,
    output logic               sel_err
);

    logic            open;
    logic [SELW-1:0] ptr;
    logic            sel_oob;
    logic            direct_hit;
    logic            scan_hit;
    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [W-1:0]    gnt_data;
    logic            is_direct;

    assign open      = !bus.out_valid || bus.out_ready;
    assign sel_oob   = {1'b0, sel} >= (SELW+1)'(N);
    assign is_direct = (mode == MODE_DIRECT) || (mode == MODE_RSVD);

    // Channel lookups by loop compare so an out-of-range sel never indexes past N
    always_comb begin
        direct_hit = 1'b0;
        scan_hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && bus.in_valid[i]) direct_hit = 1'b1;
            if (ptr == SELW'(i) && bus.in_valid[i]) scan_hit   = 1'b1;
        end
    end

    rr_arbiter #(.N(N), .SELW(SELW)) u_rr (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        case (mode)
            MODE_SCAN: begin
                gnt_vld = scan_hit;
                gnt_idx = ptr;
            end
            MODE_RR: begin
                gnt_vld = rr_vld;
                gnt_idx = rr_idx;
            end
            default: begin
                gnt_vld = direct_hit && !sel_oob;
                gnt_idx = sel;
            end
        endcase
    end

    always_comb begin
        bus.in_ready = '0;
        gnt_data     = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                bus.in_ready[i] = open && gnt_vld;
                gnt_data        = bus.in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            sel_err       <= 1'b0;
            ptr           <= '0;
        end else begin
            sel_err <= open && is_direct && sel_oob;
            if (open) begin
                // With the slot open an empty cycle simply drains the register
                bus.out_valid <= gnt_vld;
                if (gnt_vld) begin
                    bus.out_data <= gnt_data;
                    bus.out_ch   <= gnt_idx;
                end
                if (mode == MODE_SCAN) begin
                    ptr <= SELW'(next_idx(idx_t'(ptr), idx_t'(N)));
                end else if (mode == MODE_RR && gnt_vld) begin
                    ptr <= SELW'(next_idx(idx_t'(gnt_idx), idx_t'(N)));
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_stream_n
// Description : Directed self-checking bench for mux_stream_n at N=8 and N=5.
// Revision    : 1.0
// ============================================================================
module tb_mux_stream_n;
    import mux_pkg::*;

    logic       clk;
    logic       rst_n;
    mode_t      mode8, mode5;
    logic [2:0] sel8, sel5;
    logic       sel_err8, sel_err5;
    int         tests;
    int         fails;

    mux_stream_n_if #(.N(8), .W(8)) bus8 ();
    mux_stream_n_if #(.N(5), .W(8)) bus5 ();

    mux_stream_n #(.N(8), .W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .mode(mode8), .sel(sel8), .sel_err(sel_err8)
    );
    mux_stream_n #(.N(5), .W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5), .mode(mode5), .sel(sel5), .sel_err(sel_err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mode_t      mode;
        logic [2:0] sel;
        logic [7:0] valid;
        logic [7:0] exp_ready;
        logic       exp_valid;
        logic [2:0] exp_ch;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch8(input int ch, input logic [7:0] d);
        bus8.in_data[ch*8 +: 8] = d;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        mode8 = MODE_DIRECT; sel8 = 3'd0;
        mode5 = MODE_DIRECT; sel5 = 3'd0;
        bus8.in_valid = '0; bus8.out_ready = 1'b1;
        bus5.in_valid = '0; bus5.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) set_ch8(i, 8'h10 + 8'(i));
        set_ch8(3, 8'hA5);
        for (int i = 0; i < 5; i++) bus5.in_data[i*8 +: 8] = 8'h20 + 8'(i);

        vecs[0]  = '{MODE_DIRECT, 3'd3, 8'h08, 8'h08, 1'b1, 3'd3, 8'hA5};
        vecs[1]  = '{MODE_DIRECT, 3'd0, 8'hFF, 8'h01, 1'b1, 3'd0, 8'h10};
        vecs[2]  = '{MODE_DIRECT, 3'd7, 8'h80, 8'h80, 1'b1, 3'd7, 8'h17};
        vecs[3]  = '{MODE_DIRECT, 3'd5, 8'h0F, 8'h00, 1'b0, 3'd7, 8'h17};
        vecs[4]  = '{MODE_DIRECT, 3'd2, 8'h04, 8'h04, 1'b1, 3'd2, 8'h12};
        vecs[5]  = '{MODE_RSVD,   3'd6, 8'h40, 8'h40, 1'b1, 3'd6, 8'h16};
        vecs[6]  = '{MODE_RR,     3'd0, 8'h85, 8'h01, 1'b1, 3'd0, 8'h10};
        vecs[7]  = '{MODE_RR,     3'd0, 8'h85, 8'h04, 1'b1, 3'd2, 8'h12};
        vecs[8]  = '{MODE_RR,     3'd0, 8'h85, 8'h80, 1'b1, 3'd7, 8'h17};
        vecs[9]  = '{MODE_RR,     3'd0, 8'h85, 8'h01, 1'b1, 3'd0, 8'h10};
        vecs[10] = '{MODE_RR,     3'd0, 8'h85, 8'h04, 1'b1, 3'd2, 8'h12};
        vecs[11] = '{MODE_RR,     3'd0, 8'h85, 8'h80, 1'b1, 3'd7, 8'h17};
        vecs[12] = '{MODE_SCAN,   3'd0, 8'hFF, 8'h01, 1'b1, 3'd0, 8'h10};
        vecs[13] = '{MODE_SCAN,   3'd0, 8'h01, 8'h00, 1'b0, 3'd0, 8'h10};
        vecs[14] = '{MODE_RR,     3'd0, 8'h0C, 8'h04, 1'b1, 3'd2, 8'h12};
        vecs[15] = '{MODE_DIRECT, 3'd3, 8'h08, 8'h08, 1'b1, 3'd3, 8'hA5};

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_out_data",  64'(bus8.out_data),  64'd0);
        check("rst_out_ch",    64'(bus8.out_ch),    64'd0);
        check("rst_sel_err",   64'(sel_err8),       64'd0);
        check("rst_in_ready",  64'(bus8.in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: one cycle per row, out_ready held high
        for (int v = 0; v < 16; v++) begin
            mode8 = vecs[v].mode;
            sel8  = vecs[v].sel;
            bus8.in_valid = vecs[v].valid;
            #1;
            check($sformatf("vec%0d_in_ready", v), 64'(bus8.in_ready), 64'(vecs[v].exp_ready));
            tick();
            check($sformatf("vec%0d_out_valid", v), 64'(bus8.out_valid), 64'(vecs[v].exp_valid));
            check($sformatf("vec%0d_out_ch", v),    64'(bus8.out_ch),    64'(vecs[v].exp_ch));
            check($sformatf("vec%0d_out_data", v),  64'(bus8.out_data),  64'(vecs[v].exp_data));
            check($sformatf("vec%0d_sel_err", v),   64'(sel_err8),       64'd0);
        end

        // Output stall: A5 held, new word 5A waits for out_ready
        bus8.out_ready = 1'b0;
        set_ch8(3, 8'h5A);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_in_ready",  64'(bus8.in_ready),  64'd0);
            check("stall_out_data",  64'(bus8.out_data),  64'hA5);
            check("stall_out_valid", 64'(bus8.out_valid), 64'd1);
            tick();
        end
        check("stall_hold_data", 64'(bus8.out_data), 64'hA5);
        bus8.out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 64'(bus8.in_ready), 64'h08);
        tick();
        check("unstall_out_data",  64'(bus8.out_data),  64'h5A);
        check("unstall_out_valid", 64'(bus8.out_valid), 64'd1);
        set_ch8(3, 8'hA5);
        bus8.in_valid = '0;
        tick();
        check("drain_out_valid", 64'(bus8.out_valid), 64'd0);

        // Fresh reset so the scan pointer starts at 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mode8 = MODE_SCAN;
        bus8.in_valid = 8'h01;
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("scan%0d_in_ready", k), 64'(bus8.in_ready), (k % 8 == 0) ? 64'h01 : 64'h00);
            tick();
            check($sformatf("scan%0d_out_valid", k), 64'(bus8.out_valid), (k % 8 == 0) ? 64'd1 : 64'd0);
            if (k % 8 == 0) check($sformatf("scan%0d_out_ch", k), 64'(bus8.out_ch), 64'd0);
        end
        bus8.in_valid = '0;

        // N=5: out-of-range select, then legal select, then RR wrap
        sel5 = 3'd6;
        bus5.in_valid = 5'h1F;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("n5_oob_in_ready", 64'(bus5.in_ready), 64'd0);
            tick();
            check("n5_oob_out_valid", 64'(bus5.out_valid), 64'd0);
            check("n5_oob_sel_err",   64'(sel_err5),       64'd1);
        end
        sel5 = 3'd1;
        #1;
        check("n5_sel1_in_ready", 64'(bus5.in_ready), 64'h02);
        tick();
        check("n5_sel1_sel_err", 64'(sel_err5),      64'd0);
        check("n5_sel1_out_ch",  64'(bus5.out_ch),   64'd1);
        check("n5_sel1_data",    64'(bus5.out_data), 64'h21);
        mode5 = MODE_RR;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("n5_rr%0d_in_ready", k), 64'(bus5.in_ready), 64'(5'b1 << (k % 5)));
            tick();
            check($sformatf("n5_rr%0d_out_ch", k),    64'(bus5.out_ch),    64'(k % 5));
            check($sformatf("n5_rr%0d_out_valid", k), 64'(bus5.out_valid), 64'd1);
        end
        bus5.in_valid = '0;

        // Async reset during a stall with ptr moved off zero
        mode8 = MODE_RR;
        bus8.in_valid = 8'h08;
        tick();
        check("prerst_out_ch", 64'(bus8.out_ch), 64'd3);
        bus8.out_ready = 1'b0;
        tick();
        check("prerst_stall_valid", 64'(bus8.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("async_rst_out_data",  64'(bus8.out_data),  64'd0);
        check("async_rst_out_ch",    64'(bus8.out_ch),    64'd0);
        tick();
        rst_n = 1'b1;
        bus8.in_valid = 8'hFF;
        bus8.out_ready = 1'b1;
        #1;
        check("postrst_in_ready", 64'(bus8.in_ready), 64'h01);
        tick();
        check("postrst_out_ch",    64'(bus8.out_ch),    64'd0);
        check("postrst_out_valid", 64'(bus8.out_valid), 64'd1);
        bus8.in_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
